tcdm_bank_arbiter: RTL

- Shares one TCDM memory bank port among NumReq requesters (cores, DMA, accelerator streamers) ahead of a single bank of the tcdm interconnect.
- Round-robin arbitration with core-priority and a starvation guard for non-core requesters.
- Fixed-latency response routing back to the granted requester via an in-flight ID pipeline.

---
 rtl/tcdm_bank_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/tcdm_bank_arbiter.sv
// tcdm_bank_arbiter: round-robin TCDM bank arbiter with core priority, non-core starvation guard and fixed-latency response routing
// Optional per-requester grant and conflict counters are enabled by defining TCDM_BANK_ARB_PERF_EN
module tcdm_bank_arbiter #(
  parameter int NumReq      = 4,
  parameter int AddrWidth   = 10,
  parameter int DataWidth   = 64,
  parameter int MemLatency  = 1,
  parameter int StarveLimit = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq-1:0]             req_is_core_i,
  input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq-1:0]             req_write_i,
  input  logic [NumReq*DataWidth-1:0]   req_data_i,
  input  logic [NumReq*DataWidth/8-1:0] req_strb_i,
  output logic [NumReq-1:0]             rsp_valid_o,
  output logic [DataWidth-1:0]          rsp_data_o,
  output logic                          mem_valid_o,
  input  logic                          mem_ready_i,
  output logic [AddrWidth-1:0]          mem_addr_o,
  output logic                          mem_write_o,
  output logic [DataWidth-1:0]          mem_data_o,
  output logic [DataWidth/8-1:0]        mem_strb_o,
  input  logic [DataWidth-1:0]          mem_rdata_i
`ifdef TCDM_BANK_ARB_PERF_EN
  ,
  output logic [NumReq*32-1:0]          perf_grant_cnt_o,
  output logic [31:0]                   perf_conflict_cnt_o,
  input  logic                          perf_clear_i
`endif
);
  localparam int StrbWidth = DataWidth / 8;
  localparam int IdxWidth = NumReq > 1 ? $clog2(NumReq) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumReq - 1);
  localparam logic [7:0] Limit = 8'(StarveLimit);

  logic [IdxWidth-1:0] ptr_q, win, k;
  logic [7:0]          starve_q;
  logic [NumReq-1:0]   core_v, noncore_v, cand, win_oh, rsp_oh;
  logic                any_valid, any_noncore, found, sel, xfer;
  logic [MemLatency-1:0] pv_q;
  logic [IdxWidth-1:0] pid_q [MemLatency];

  assign core_v      = req_valid_i & req_is_core_i;
  assign noncore_v   = req_valid_i & ~req_is_core_i;
  assign any_valid   = |req_valid_i;
  assign any_noncore = |noncore_v;
  assign cand = (starve_q == Limit && any_noncore) ? noncore_v : (|core_v) ? core_v : req_valid_i;
  // Outputs are gated by rst_ni so they return to idle asynchronously with reset
  assign sel  = rst_ni & any_valid;
  assign xfer = sel & mem_ready_i;

  always_comb begin
    win = '0;
    found = 1'b0;
    k = ptr_q;
    for (int i = 0; i < NumReq; i++) begin
      if (!found && cand[k]) begin
        win = k;
        found = 1'b1;
      end
      k = (k == LastIdx) ? '0 : k + IdxWidth'(1);
    end
  end

  always_comb begin
    win_oh = '0;
    win_oh[win] = 1'b1;
  end

  assign req_ready_o = xfer ? win_oh : '0;
  assign mem_valid_o = sel;
  assign mem_addr_o  = sel ? req_addr_i[win*AddrWidth +: AddrWidth] : '0;
  assign mem_write_o = sel & req_write_i[win];
  assign mem_data_o  = sel ? req_data_i[win*DataWidth +: DataWidth] : '0;
  assign mem_strb_o  = sel ? req_strb_i[win*StrbWidth +: StrbWidth] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      starve_q <= '0;
    end else begin
      if (xfer) ptr_q <= (win == LastIdx) ? '0 : win + IdxWidth'(1);
      if (!any_noncore || (xfer && !req_is_core_i[win])) starve_q <= '0;
      else if (xfer && starve_q != Limit) starve_q <= starve_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pv_q <= '0;
      for (int j = 0; j < MemLatency; j++) pid_q[j] <= '0;
    end else begin
      pv_q[0] <= xfer;
      pid_q[0] <= win;
      for (int j = 1; j < MemLatency; j++) begin
        pv_q[j] <= pv_q[j-1];
        pid_q[j] <= pid_q[j-1];
      end
    end
  end

  always_comb begin
    rsp_oh = '0;
    rsp_oh[pid_q[MemLatency-1]] = 1'b1;
  end

  assign rsp_valid_o = pv_q[MemLatency-1] ? rsp_oh : '0;
  assign rsp_data_o  = pv_q[MemLatency-1] ? mem_rdata_i : '0;

`ifdef TCDM_BANK_ARB_PERF_EN
  logic [31:0] grant_cnt_q [NumReq];
  logic [31:0] conflict_q;
  logic        conflict;

  assign conflict = (|(req_valid_i & (req_valid_i - NumReq'(1)))) || (any_valid && !mem_ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumReq; i++) grant_cnt_q[i] <= '0;
      conflict_q <= '0;
    end else if (perf_clear_i) begin
      for (int i = 0; i < NumReq; i++) grant_cnt_q[i] <= '0;
      conflict_q <= '0;
    end else begin
      for (int i = 0; i < NumReq; i++)
        if (xfer && win == IdxWidth'(i) && grant_cnt_q[i] != '1) grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
      if (conflict) conflict_q <= conflict_q + 32'd1;
    end
  end

  for (genvar g = 0; g < NumReq; g++) begin : g_perf
    assign perf_grant_cnt_o[g*32 +: 32] = grant_cnt_q[g];
  end
  assign perf_conflict_cnt_o = conflict_q;
`endif
endmodule
